alu_acc_unit: RTL and testbench
===============================

Name: alu_acc_unit

Overview:
- Datapath execute stage directly downstream of the MMA control unit.
- Consumes the control vector, holds ACC and the R0 operand register, and performs ADD/SUB into a result latch.
- Drives ACC onto the write bus and returns the 16-bit PSW that the control unit tests for JNE.
- Two-step ALU handshake: ADD_OP/SUB_OP computes; ACC_ALU commits.

Parameters:
- DATA_WIDTH, 16, width of ACC, R0, result latch, rbus and wbus.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- control  input  [0:`MAX_CONTROL_LINES-1]  control vector; bits indexed by the shared control-signal macros.
- rbus  input  DATA_WIDTH  read bus (memory/IR data).
- wbus  output  DATA_WIDTH  write bus; always equals ACC.
- r0  output  DATA_WIDTH  operand register, for the MR/PC loads.
- psw  output  16  status word.
- alu_fault  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset==0, async):
  - ACC, R0 and the result latch clear to 0.
  - psw clears to 16'h8000 (Z=1).
  - alu_fault clears to 0.
  - State goes to IDLE.
- PSW bits:
  - [15] Z, [14] N, [13] C, [12] V.
  - [11] RV, result valid (1 in HELD).
  - [10] copy of alu_fault.
  - [9:0] are 0.
- ACC_RBUS: ACC <= rbus at the next edge. Z and N are updated from rbus; C and V are cleared.
- R0_RBUS: R0 <= rbus at the next edge.
- State machine, 2 states: IDLE and HELD.
  - IDLE + ADD_OP:
    - result <= ACC+R0, using the registered R0 from before this edge.
    - C = carry-out; V = signed overflow.
    - Z/N taken from the result.
    - Go to HELD.
  - IDLE + SUB_OP:
    - result <= ACC-R0.
    - C = borrow (1 when ACC<R0 unsigned); V = signed overflow.
    - Z/N taken from the result.
    - Go to HELD.
  - HELD + ACC_ALU: ACC <= result; go to IDLE; flags unchanged.
  - HELD + ADD_OP/SUB_OP: recompute, overwrite the result, stay in HELD (legal).
  - IDLE + ACC_ALU: no ACC change; alu_fault <= 1.
- Latency:
  - Flags are visible one cycle after ADD_OP/SUB_OP.
  - ACC is visible one cycle after ACC_ALU.
  - The control unit issues ACC_ALU in the following state, so a full op takes 2 cycles.
- Wrap-around: arithmetic is modulo 2^DATA_WIDTH. 16'hFFFF+1 gives 0 with C=1, Z=1.
- Simultaneous events, each sets alu_fault and updates nothing for that op:
  - ADD_OP and SUB_OP together: no state/flag change.
  - ACC_RBUS and ACC_ALU together: ACC unchanged; state unchanged.
- R0_RBUS together with ADD/SUB is legal; the op uses the old R0.
- alu_fault is sticky until reset.
- An all-zero control vector holds every register.
- Reset asserted mid-operation (HELD) discards the result; the unit returns to IDLE.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined: on signed overflow, the result saturates to the most-positive/most-negative DATA_WIDTH value. V is still set; C is still set on unsigned carry/borrow.
- Undefined: modulo wrap as above; no saturation logic is synthesized.

Decomposition:
- Shared package/header holds:
  - PSW bit-position constants (PSW_Z=15, PSW_N=14, PSW_C=13, PSW_V=12, PSW_RV=11, PSW_FLT=10).
  - The state encodings IDLE/HELD.
- Control-line indices come from the existing control-signal header.
- One sub-module: alu_addsub, combinational adder/subtractor. Inputs a, b, sub. Outputs sum, carry, overflow, plus the saturation option.
- The registered unit instantiates alu_addsub.

Test Plan:
- Reset low mid-HELD:
  - ACC=0, R0=0, psw=16'h8000, alu_fault=0 immediately (async).
  - After release, ACC_ALU sets alu_fault.
- ACC_RBUS rbus=16'h0005, R0_RBUS rbus=16'h0003, ADD_OP, ACC_ALU:
  - After ADD_OP, psw=16'h0800.
  - After ACC_ALU, ACC=wbus=16'h0008, psw=16'h0000.
- ACC=16'h0003, R0=16'h0003, SUB_OP, ACC_ALU:
  - ACC=0, Z=1, C=0; JNE sees psw[15]=1.
  - ACC=16'h0002, R0=16'h0003, SUB: ACC=16'hFFFF, N=1, C=1.
- ACC=16'h7FFF, R0=16'h0001, ADD:
  - Default: 16'h8000, V=1, N=1.
  - With ALU_SATURATE_EN: 16'h7FFF, V=1.
- ADD_OP+SUB_OP in the same cycle:
  - alu_fault=1, psw[10]=1, flags/state unchanged.
  - ACC_RBUS+ACC_ALU in HELD: ACC unchanged, still HELD.
- R0_RBUS rbus=16'h0010 with ADD_OP, old R0=1, ACC=2:
  - result=3, R0=16'h0010 afterwards.

Source files
------------

// File: rtl/alu_acc_unit_pkg.sv
// alu_acc_unit_pkg: control-line indices, PSW bit positions and state encoding for alu_acc_unit
package alu_acc_unit_pkg;
  localparam int MAX_CONTROL_LINES = 5;
  localparam int CTL_ACC_RBUS = 0;
  localparam int CTL_R0_RBUS = 1;
  localparam int CTL_ADD_OP = 2;
  localparam int CTL_SUB_OP = 3;
  localparam int CTL_ACC_ALU = 4;
  localparam int PSW_Z = 15;
  localparam int PSW_N = 14;
  localparam int PSW_C = 13;
  localparam int PSW_V = 12;
  localparam int PSW_RV = 11;
  localparam int PSW_FLT = 10;
  typedef enum logic {IDLE, HELD} state_t;
endpackage

// File: rtl/alu_acc_unit_addsub.sv
// alu_addsub: combinational adder/subtractor; ALU_SATURATE_EN clamps signed overflow
module alu_addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         overflow
);
  logic [W:0] raw;
  assign raw = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
  assign carry = raw[W];
  // operand signs agree (add) or differ (sub) and the result sign flipped
  assign overflow = (a[W-1] ^ b[W-1] ^ ~sub) & (raw[W-1] ^ a[W-1]);
`ifdef ALU_SATURATE_EN
  assign sum = overflow ? {a[W-1], {(W-1){~a[W-1]}}} : raw[W-1:0];
`else
  assign sum = raw[W-1:0];
`endif
endmodule

// File: rtl/alu_acc_unit.sv
// alu_acc_unit: ACC/R0 execute stage with two-step ADD/SUB then ACC_ALU commit, PSW and sticky fault
// Optional ALU_SATURATE_EN: saturate the result on signed overflow.
module alu_acc_unit
  import alu_acc_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [0:MAX_CONTROL_LINES-1] control,
  input  logic [DATA_WIDTH-1:0]       rbus,
  output logic [DATA_WIDTH-1:0]       wbus,
  output logic [DATA_WIDTH-1:0]       r0,
  output logic [15:0]                 psw,
  output logic                        alu_fault
);
  logic [DATA_WIDTH-1:0] acc, result, sum;
  logic z, n, c, v, carry, overflow;
  state_t state;
  logic acc_rbus, r0_rbus, add_op, sub_op, acc_alu;
  assign acc_rbus = control[CTL_ACC_RBUS];
  assign r0_rbus = control[CTL_R0_RBUS];
  assign add_op = control[CTL_ADD_OP];
  assign sub_op = control[CTL_SUB_OP];
  assign acc_alu = control[CTL_ACC_ALU];
  alu_addsub #(.W(DATA_WIDTH)) u_addsub (
    .a(acc), .b(r0), .sub(sub_op), .sum(sum), .carry(carry), .overflow(overflow)
  );
  assign wbus = acc;
  always_comb begin
    psw = '0;
    psw[PSW_Z] = z;
    psw[PSW_N] = n;
    psw[PSW_C] = c;
    psw[PSW_V] = v;
    psw[PSW_RV] = state == HELD;
    psw[PSW_FLT] = alu_fault;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      r0 <= '0;
      result <= '0;
      {z, n, c, v} <= 4'b1000;
      alu_fault <= 1'b0;
      state <= IDLE;
    end else begin
      if (r0_rbus) r0 <= rbus;
      if ((add_op & sub_op) | (acc_rbus & acc_alu) | (acc_alu & state == IDLE)) alu_fault <= 1'b1;
      if (acc_rbus & ~acc_alu) begin
        acc <= rbus;
        {z, n, c, v} <= {rbus == '0, rbus[DATA_WIDTH-1], 2'b00};
      end
      // a valid op outranks a same-cycle commit; the op sees pre-edge ACC/R0
      if (add_op ^ sub_op) begin
        result <= sum;
        {z, n, c, v} <= {sum == '0, sum[DATA_WIDTH-1], carry, overflow};
        state <= HELD;
      end else if (acc_alu & ~acc_rbus & state == HELD) begin
        acc <= result;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_acc_unit.sv
// tb_alu_acc_unit: random and directed checks of alu_acc_unit against an arithmetic reference model
module tb_alu_acc_unit;
  import alu_acc_unit_pkg::*;
  localparam logic [4:0] ARB = 5'b00001, RRB = 5'b00010, ADD = 5'b00100, SUB = 5'b01000, ALU = 5'b10000;
  logic clk = 0, reset = 0;
  logic [0:MAX_CONTROL_LINES-1] control = '0;
  logic [15:0] rbus = '0, wbus, r0, psw;
  logic alu_fault;
  int n_tests = 0, n_fail = 0;
  int m_acc, m_r0, m_res;
  bit m_z, m_n, m_c, m_v, m_held, m_flt;

  alu_acc_unit #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .control(control), .rbus(rbus),
    .wbus(wbus), .r0(r0), .psw(psw), .alu_fault(alu_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_psw();
    return {m_z, m_n, m_c, m_v, m_held, m_flt, 10'b0};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_r0 = 0; m_res = 0;
    {m_z, m_n, m_c, m_v, m_held, m_flt} = 6'b100000;
  endtask

  task automatic model_step(input logic [4:0] k, input int rb);
    int a, b, sa, sb, u, s, r;
    bit arb, rrb, add, sub, alu;
    {alu, sub, add, rrb, arb} = k;
    a = m_acc; b = m_r0;
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    if ((add && sub) || (arb && alu) || (alu && !m_held)) m_flt = 1;
    if (arb && !alu) begin
      m_acc = rb; m_z = rb == 0; m_n = rb >= 32768; m_c = 0; m_v = 0;
    end
    if (add != sub) begin
      u = add ? a + b : a - b;
      s = add ? sa + sb : sa - sb;
      m_c = add ? u > 65535 : a < b;
      m_v = s > 32767 || s < -32768;
      r = u & 16'hFFFF;
`ifdef ALU_SATURATE_EN
      if (m_v) r = s > 0 ? 32767 : 32768;
`endif
      m_res = r; m_z = r == 0; m_n = r >= 32768; m_held = 1;
    end else if (alu && !arb && m_held) begin
      m_acc = m_res; m_held = 0;
    end
    if (rrb) m_r0 = rb;
  endtask

  task automatic check_all();
    chk("wbus", wbus, m_acc[15:0]);
    chk("r0", r0, m_r0[15:0]);
    chk("psw", psw, m_psw());
    chk("alu_fault", alu_fault, m_flt);
  endtask

  task automatic step(input logic [4:0] k, input logic [15:0] rb);
    control = '0;
    control[CTL_ACC_RBUS] = k[0];
    control[CTL_R0_RBUS] = k[1];
    control[CTL_ADD_OP] = k[2];
    control[CTL_SUB_OP] = k[3];
    control[CTL_ACC_ALU] = k[4];
    rbus = rb;
    @(posedge clk);
    model_step(k, int'(rb));
    #1;
    check_all();
    control = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    model_reset();
    chk("rst_wbus", wbus, 0);
    chk("rst_r0", r0, 0);
    chk("rst_psw", psw, 16'h8000);
    chk("rst_fault", alu_fault, 0);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    // async reset while HELD
    step(ARB, 16'h0009); step(RRB, 16'h0004); step(ADD, 0);
    chk("held_rv", psw[PSW_RV], 1);
    do_reset();
    step(ALU, 0);
    chk("idle_alu_fault", alu_fault, 1);
    do_reset();
    // 5 + 3
    step(ARB, 16'h0005); step(RRB, 16'h0003); step(ADD, 0);
    chk("add_psw", psw, 16'h0800);
    step(ALU, 0);
    chk("add_acc", wbus, 16'h0008);
    chk("add_psw_commit", psw, 16'h0000);
    // 3 - 3 and 2 - 3
    step(ARB, 16'h0003); step(SUB, 0); step(ALU, 0);
    chk("sub_zero", wbus, 0);
    chk("sub_zero_z", psw[PSW_Z], 1);
    chk("sub_zero_c", psw[PSW_C], 0);
    step(ARB, 16'h0002); step(SUB, 0); step(ALU, 0);
    chk("sub_neg", wbus, 16'hFFFF);
    chk("sub_neg_n", psw[PSW_N], 1);
    chk("sub_neg_c", psw[PSW_C], 1);
    // FFFF + 1 wraps
    step(RRB, 16'h0001); step(ADD, 0); step(ALU, 0);
    chk("wrap_acc", wbus, 0);
    chk("wrap_zc", {psw[PSW_Z], psw[PSW_C]}, 2'b11);
    // signed overflow
    step(ARB, 16'h7FFF); step(ADD, 0); step(ALU, 0);
`ifdef ALU_SATURATE_EN
    chk("ovf_acc", wbus, 16'h7FFF);
`else
    chk("ovf_acc", wbus, 16'h8000);
    chk("ovf_n", psw[PSW_N], 1);
`endif
    chk("ovf_v", psw[PSW_V], 1);
    chk("ovf_fault_clean", alu_fault, 0);
    // conflicting controls
    step(ADD | SUB, 0);
    chk("conflict_fault", alu_fault, 1);
    chk("conflict_psw", psw, 16'h1400 | (psw[PSW_N] ? 16'h4000 : 16'h0));
    chk("conflict_rv", psw[PSW_RV], 0);
    step(ADD, 0);
    step(ARB | ALU, 16'h1234);
    chk("arb_alu_rv", psw[PSW_RV], 1);
    chk("arb_alu_acc_kept", wbus == 16'h1234, 0);
    // R0 load alongside an op uses old R0
    do_reset();
    step(ARB, 16'h0002); step(RRB, 16'h0001); step(RRB | ADD, 16'h0010);
    chk("r0_new", r0, 16'h0010);
    step(ALU, 0);
    chk("r0_old_sum", wbus, 16'h0003);
    step(5'b00000, 16'hBEEF);
    // random traffic with periodic resets
    for (int i = 0; i < 600; i++) begin
      logic [4:0] k;
      if (i % 60 == 59) do_reset();
      k = '0;
      for (int j = 0; j < 5; j++) k[j] = ($urandom_range(0, 3) == 0);
      step(k, 16'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
